// File: rtl/lenet_c1_sched.sv
// rtl/lenet_c1_sched.sv - LeNet C1 sequencer: per-map weight/bias load, raster replay, drain
module lenet_c1_sched #(
  parameter int WW     = 7,
  parameter int N_MAP  = 6,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int HS_PRE = 4,
  parameter int HBLANK = 4,
  parameter int DRAIN  = 16
) (
  input  logic          i_sclk,
  input  logic          i_rstn,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [2:0]    o_map_idx,
  output logic [7:0]    o_wmem_addr,
  input  logic [WW-1:0] i_wmem_data,
  output logic [9:0]    o_pix_addr,
  input  logic          i_pix_data,
  output logic          o_W_en,
  output logic [4:0]    o_W_addr,
  output logic [WW-1:0] o_Weight,
  output logic [WW-1:0] o_Bias,
  output logic          o_vsync,
  output logic          o_hsync,
  output logic          o_valid,
  output logic          o_tdata
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_ROW_HS   = 3'd2;
  localparam logic [2:0] S_ROW_DATA = 3'd3;
  localparam logic [2:0] S_ROW_GAP  = 3'd4;
  localparam logic [2:0] S_DRAIN    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [15:0] LOAD_END  = 16'd27;
  localparam logic [15:0] HS_END    = 16'(HS_PRE - 1);
  localparam logic [15:0] DATA_END  = 16'(IMG_W - 1);
  localparam logic [15:0] GAP_END   = 16'(HBLANK - 1);
  localparam logic [15:0] DRAIN_END = 16'(DRAIN - 1);
  localparam logic [15:0] ROW_END   = 16'(IMG_H - 1);
  localparam logic [7:0]  MAP_END   = 8'(N_MAP - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [15:0] row;
  logic [7:0]  map;
  logic        cnt_end;
  logic [15:0] wmem_full;
  logic [15:0] pix_full;

  always_comb begin
    cnt_end = 1'b0;
    case (state)
      S_LOAD:     cnt_end = (cnt == LOAD_END);
      S_ROW_HS:   cnt_end = (cnt == HS_END);
      S_ROW_DATA: cnt_end = (cnt == DATA_END);
      S_ROW_GAP:  cnt_end = (cnt == GAP_END);
      S_DRAIN:    cnt_end = (cnt == DRAIN_END);
      default:    cnt_end = 1'b0;
    endcase
  end

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
      row   <= '0;
      map   <= '0;
    end else begin
      cnt <= cnt_end ? 16'd0 : cnt + 16'd1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          row <= '0;
          map <= '0;
          if (i_start) state <= S_LOAD;
        end
        S_LOAD:     if (cnt_end) state <= S_ROW_HS;
        S_ROW_HS:   if (cnt_end) state <= S_ROW_DATA;
        S_ROW_DATA: if (cnt_end) state <= S_ROW_GAP;
        S_ROW_GAP: if (cnt_end) begin
          if (row == ROW_END) begin
            row   <= '0;
            state <= S_DRAIN;
          end else begin
            row   <= row + 16'd1;
            state <= S_ROW_HS;
          end
        end
        S_DRAIN: if (cnt_end) begin
          if (map == MAP_END) begin
            map   <= '0;
            state <= S_DONE;
          end else begin
            map   <= map + 8'd1;
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wmem_full   = {8'd0, map} * 16'd26 + cnt;
  assign pix_full    = row * 16'(IMG_W) + cnt;
  assign o_wmem_addr = (state == S_LOAD && cnt < 16'd26) ? wmem_full[7:0] : 8'd0;
  assign o_pix_addr  = (state == S_ROW_DATA) ? pix_full[9:0] : 10'd0;
  assign o_busy      = (state != S_IDLE) && (state != S_DONE);
  assign o_done      = (state == S_DONE);
  assign o_map_idx   = map[2:0];

  // Every strobe passes through two registers so it lines up with 1-cycle memory data
  logic       vs_d1, hs_d1, rd_d1, we_d1, bias_d1;
  logic [4:0] wa_d1;

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      vs_d1    <= 1'b0;
      hs_d1    <= 1'b0;
      rd_d1    <= 1'b0;
      we_d1    <= 1'b0;
      bias_d1  <= 1'b0;
      wa_d1    <= '0;
      o_vsync  <= 1'b0;
      o_hsync  <= 1'b0;
      o_valid  <= 1'b0;
      o_tdata  <= 1'b0;
      o_W_en   <= 1'b0;
      o_W_addr <= '0;
      o_Weight <= '0;
      o_Bias   <= '0;
    end else begin
      vs_d1    <= (state == S_LOAD);
      hs_d1    <= (state == S_ROW_HS) && (cnt == 16'd0);
      rd_d1    <= (state == S_ROW_DATA);
      we_d1    <= (state == S_LOAD) && (cnt < 16'd25);
      bias_d1  <= (state == S_LOAD) && (cnt == 16'd25);
      wa_d1    <= cnt[4:0];
      o_vsync  <= vs_d1;
      o_hsync  <= hs_d1;
      o_valid  <= rd_d1;
      o_tdata  <= rd_d1 ? i_pix_data : 1'b0;
      o_W_en   <= we_d1;
      o_W_addr <= wa_d1;
      if (we_d1) o_Weight <= i_wmem_data;
      if (bias_d1) o_Bias <= i_wmem_data;
    end
  end

endmodule
